// File: rtl/uart_pkg.sv
// Shared constants and types for the UART register bridge: host command bytes,
// default response bytes, bridge FSM states and the local-bus request payload.
package uart_pkg;

    localparam logic [7:0] CMD_WR      = 8'h57;
    localparam logic [7:0] CMD_RD      = 8'h52;
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_CAP,
        ST_SEND,
        ST_SEND_WAIT
    } bridge_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
    } reg_req_t;

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// Decodes host frames ('W' addr data / 'R' addr) from the UART receive side into
// single-byte local-bus accesses and answers with ACK, NAK or the read byte.
module uart_reg_bridge
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 21_700,
    parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE     = NAK_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_tx_wr,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,
    output logic       o_reg_wr,
    output logic       o_reg_rd,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    input  logic [7:0] i_reg_rdata,
    output logic       o_err
);

    localparam int unsigned    CNT_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS - 1);

    bridge_state_e    state_q, state_d;
    logic             is_wr_q, is_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    reg_req_t         req_q, req_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_wr_q, tx_wr_d;
    logic             reg_wr_q, reg_wr_d;
    logic             reg_rd_q, reg_rd_d;
    logic             err_q, err_d;

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        reg_wr_d  = 1'b0;
        reg_rd_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (is_known_cmd(i_rx_data)) begin
                        is_wr_d = (i_rx_data == CMD_WR);
                        cnt_d   = '0;
                        state_d = ST_GET_ADDR;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        err_d     = 1'b1;
                        state_d   = ST_SEND;
                    end
                end
            end

            ST_GET_ADDR: begin
                if (i_rx_valid) begin
                    req_d.addr = i_rx_data;
                    if (is_wr_q) begin
                        cnt_d   = '0;
                        state_d = ST_GET_DATA;
                    end else begin
                        reg_rd_d = 1'b1;
                        state_d  = ST_BUS_RD;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GET_DATA: begin
                if (i_rx_valid) begin
                    req_d.wdata = i_rx_data;
                    reg_wr_d    = 1'b1;
                    state_d     = ST_BUS_WR;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_BUS_WR: begin
                tx_data_d = ACK_BYTE;
                state_d   = ST_SEND;
            end

            ST_BUS_RD: begin
                state_d = ST_RD_CAP;
            end

            // Read data is valid the cycle after the read strobe.
            ST_RD_CAP: begin
                tx_data_d = i_reg_rdata;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                if (!i_tx_busy) begin
                    tx_wr_d = 1'b1;
                    state_d = ST_SEND_WAIT;
                end
            end

            // Transmitter raises busy one cycle after the write, so skip the first cycle.
            ST_SEND_WAIT: begin
                if (!tx_wr_q && !i_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            req_q     <= '0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            reg_wr_q  <= 1'b0;
            reg_rd_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            reg_wr_q  <= reg_wr_d;
            reg_rd_q  <= reg_rd_d;
            err_q     <= err_d;
        end
    end

    assign o_tx_wr     = tx_wr_q;
    assign o_tx_data   = tx_data_q;
    assign o_reg_wr    = reg_wr_q;
    assign o_reg_rd    = reg_rd_q;
    assign o_reg_addr  = req_q.addr;
    assign o_reg_wdata = req_q.wdata;
    assign o_err       = err_q;

endmodule
